// File: rtl/rgb_capture_pkg.sv
// Shared types and helpers for the single-shot RGB frame grabber.
// Holds the capture state encoding, default geometry and the RGB565 packer.
package rgb_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIX_TOTAL    = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int CNT_W        = 19;

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module capture_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; dout is forced to zero while
  // empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rgb_frame_capture.sv
// Single-shot frame grabber: packs one RGB888 frame into RGB565 pixel pairs
// and queues the 32-bit words for the snapshot memory writer.
module rgb_frame_capture
  import rgb_capture_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             VGA_CLK,
  input  logic             RST_N,
  input  logic [7:0]       iRed,
  input  logic [7:0]       iGreen,
  input  logic [7:0]       iBlue,
  input  logic             READ_Request,
  input  logic             VGA_VS,
  input  logic             iCapture,
  input  logic             iAbort,
  output logic [31:0]      oWord,
  output logic             oWordValid,
  input  logic             iWordReady,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOverflow,
  output logic             oShortFrame,
  output logic [CNT_W-1:0] oPixCount
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic        vs_prev;
  logic        vs_edge;
  logic [15:0] pix565;
  logic [15:0] half_q;
  logic [31:0] word_q;
  logic        push_q;
  logic        accept, arm, short_edge;
  logic        fifo_full, fifo_empty, pop;

  assign vs_edge    = !vs_prev && VGA_VS;
  assign pix565     = rgb565(iRed, iGreen, iBlue);
  assign pop        = !fifo_empty && iWordReady;
  assign oWordValid = !fifo_empty;
  assign oBusy      = state_q inside {S_ARMED, S_CAPTURE, S_DRAIN};
  assign oDone      = (state_q == S_DONE);

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    arm        = 1'b0;
    short_edge = 1'b0;
    if (iAbort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (iCapture) begin
          state_d = S_ARMED;
          arm     = 1'b1;
        end
        S_ARMED: if (vs_edge) state_d = S_CAPTURE;
        S_CAPTURE: begin
          if (vs_edge) begin
            state_d    = S_DRAIN;
            short_edge = 1'b1;
          end else if (READ_Request) begin
            accept = 1'b1;
            if (oPixCount == LAST_PIX) state_d = S_DRAIN;
          end
        end
        S_DRAIN: if (fifo_empty && !push_q) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      vs_prev     <= 1'b1;
      half_q      <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      oPixCount   <= '0;
      oOverflow   <= 1'b0;
      oShortFrame <= 1'b0;
    end else begin
      vs_prev <= VGA_VS;
      push_q  <= 1'b0;
      if (iAbort || arm) half_q <= '0;
      if (arm) begin
        oPixCount   <= '0;
        oOverflow   <= 1'b0;
        oShortFrame <= 1'b0;
      end
      // Pixel parity comes from the count, which restarts at zero on arm.
      if (accept) begin
        oPixCount <= oPixCount + CNT_W'(1);
        if (!oPixCount[0]) begin
          half_q <= pix565;
        end else begin
          word_q <= {pix565, half_q};
          push_q <= 1'b1;
        end
      end
      if (short_edge) oShortFrame <= 1'b1;
      if (push_q && !iAbort && fifo_full && !pop) oOverflow <= 1'b1;
    end
  end

  capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (VGA_CLK),
    .rst_n (RST_N),
    .flush (iAbort),
    .push  (push_q),
    .pop   (pop),
    .din   (word_q),
    .dout  (oWord),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_rgb_frame_capture.sv
// Self-checking bench for rgb_frame_capture: a 4x2 instance for frame
// scenarios and a 4x4 instance for back-pressure and randomized frames.
module tb_rgb_frame_capture;

  localparam int H  = 4;
  localparam int VA = 2;
  localparam int VB = 4;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        read_req = 1'b0, vs = 1'b1, capture = 1'b0, abort = 1'b0, ready = 1'b1;

  logic [31:0] word_a, word_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic        ovf_a, ovf_b, short_a, short_b;
  logic [18:0] cnt_a, cnt_b;

  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] got_a[$];
  logic [31:0] got_b[$];
  logic [15:0] pix_q[$];
  logic [7:0]  pr, pg, pb;

  always #5 clk = ~clk;

  rgb_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(VA), .FIFO_DEPTH(D)) dut_a (
    .VGA_CLK(clk), .RST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .READ_Request(read_req), .VGA_VS(vs), .iCapture(capture), .iAbort(abort),
    .oWord(word_a), .oWordValid(valid_a), .iWordReady(ready), .oBusy(busy_a),
    .oDone(done_a), .oOverflow(ovf_a), .oShortFrame(short_a), .oPixCount(cnt_a));

  rgb_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(VB), .FIFO_DEPTH(D)) dut_b (
    .VGA_CLK(clk), .RST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .READ_Request(read_req), .VGA_VS(vs), .iCapture(capture), .iAbort(abort),
    .oWord(word_b), .oWordValid(valid_b), .iWordReady(ready), .oBusy(busy_b),
    .oDone(done_b), .oOverflow(ovf_b), .oShortFrame(short_b), .oPixCount(cnt_b));

  // Inputs change just after posedge, so the negedge view equals the next edge's.
  always @(negedge clk) begin
    if (valid_a && ready) got_a.push_back(word_a);
    if (valid_b && ready) got_b.push_back(word_b);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    int npix;
    bit short_end;
    int exp_words;
    int exp_cnt;
    bit exp_short;
  } vec_t;

  function automatic logic [15:0] to565(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    int v;
    v = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + int'(b) / 8;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) ready = !ready ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit accepted);
    red = r; green = g; blue = b; read_req = 1'b1;
    step();
    read_req = 1'b0;
    if (accepted) pix_q.push_back(to565(r, g, b));
  endtask

  task automatic start_capture();
    abort = 1'b1;
    step();
    abort = 1'b0;
    got_a.delete();
    got_b.delete();
    pix_q.delete();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  task automatic vs_edge();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  task automatic wait_done(input string name, input bit use_b, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (use_b ? done_b : done_a) break;
      step();
    end
    check(name, 32'(use_b ? done_b : done_a), 32'd1);
  endtask

  task automatic check_stream(input string name, input bit use_b, input int nwords);
    int n;
    logic [31:0] g;
    n = use_b ? got_b.size() : got_a.size();
    check({name, "_nwords"}, 32'(n), 32'(nwords));
    for (int k = 0; k < nwords && k < n; k++) begin
      g = use_b ? got_b[k] : got_a[k];
      check($sformatf("%s_w%0d", name, k), g,
            32'(pix_q[2*k+1]) * 32'd65536 + 32'(pix_q[2*k]));
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8, 1'b0, 4, 8, 1'b0};
    vecs[1] = '{5, 1'b1, 2, 5, 1'b1};
    vecs[2] = '{10, 1'b0, 4, 8, 1'b0};
    vecs[3] = '{0, 1'b1, 0, 0, 1'b1};
    vecs[4] = '{3, 1'b1, 1, 3, 1'b1};

    // Reset state
    #3;
    check("rst_word", word_a, 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_short", 32'(short_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven frame scenarios on the 4x2 instance
    for (int v = 0; v < 5; v++) begin
      start_capture();
      vs_edge();
      for (int i = 0; i < vecs[v].npix; i++) begin
        if (v == 0) begin
          pr = (i % 2 == 0) ? 8'hFF : 8'h00;
          pg = pr;
          pb = pr;
        end else begin
          pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
        end
        send_pixel(pr, pg, pb, i < H * VA);
      end
      if (vecs[v].short_end) vs_edge();
      wait_done($sformatf("vec%0d_done", v), 1'b0, 40);
      check($sformatf("vec%0d_cnt", v), 32'(cnt_a), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_short", v), 32'(short_a), 32'(vecs[v].exp_short));
      check($sformatf("vec%0d_ovf", v), 32'(ovf_a), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy_a), 32'd0);
      check_stream($sformatf("vec%0d", v), 1'b0, vecs[v].exp_words);
      if (v == 0 && got_a.size() > 0) check("basic_literal", got_a[0], 32'h0000FFFF);
    end

    // Back-pressure: 16 pixels into a 4-word FIFO with the consumer stalled
    ready = 1'b0;
    start_capture();
    vs_edge();
    for (int i = 0; i < H * VB; i++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    repeat (3) step();
    check("bp_ovf", 32'(ovf_b), 32'd1);
    check("bp_cnt", 32'(cnt_b), 32'd16);
    check("bp_valid", 32'(valid_b), 32'd1);
    check("bp_busy", 32'(busy_b), 32'd1);
    check("bp_not_done", 32'(done_b), 32'd0);
    ready = 1'b1;
    wait_done("bp_done", 1'b1, 40);
    check_stream("bp", 1'b1, 4);

    // Output latency and abort with a word queued
    ready = 1'b0;
    start_capture();
    vs_edge();
    send_pixel(8'h12, 8'h34, 8'h56, 1'b1);
    send_pixel(8'h9A, 8'hBC, 8'hDE, 1'b1);
    check("lat_not_yet", 32'(valid_a), 32'd0);
    send_pixel(8'h11, 8'h22, 8'h33, 1'b1);
    check("lat_valid", 32'(valid_a), 32'd1);
    check("lat_word", word_a, 32'(pix_q[1]) * 32'd65536 + 32'(pix_q[0]));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_cnt", 32'(cnt_a), 32'd3);
    capture = 1'b1;
    step();
    capture = 1'b0;
    check("rearm_cnt", 32'(cnt_a), 32'd0);
    check("rearm_busy", 32'(busy_a), 32'd1);
    ready = 1'b1;

    // Capture and abort together from IDLE: abort wins
    abort = 1'b1;
    step();
    capture = 1'b1;
    step();
    capture = 1'b0;
    abort = 1'b0;
    check("cap_abort_busy", 32'(busy_a), 32'd0);
    check("cap_abort_done", 32'(done_a), 32'd0);

    // Pixels while ARMED are ignored; iCapture during CAPTURE is ignored
    start_capture();
    send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b0);
    send_pixel(8'hDD, 8'hEE, 8'hFF, 1'b0);
    check("armed_cnt", 32'(cnt_a), 32'd0);
    check("armed_busy", 32'(busy_a), 32'd1);
    vs_edge();
    for (int i = 0; i < 3; i++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    capture = 1'b1;
    step();
    capture = 1'b0;
    check("cap_in_capture_cnt", 32'(cnt_a), 32'd3);
    for (int i = 0; i < 5; i++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    wait_done("edge_done", 1'b0, 40);
    check("edge_cnt", 32'(cnt_a), 32'd8);
    check_stream("edge", 1'b0, 4);

    // Asynchronous reset in the middle of a capture
    ready = 1'b0;
    start_capture();
    vs_edge();
    for (int i = 0; i < 4; i++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_word", word_a, 32'd0);
    check("arst_cnt", 32'(cnt_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    check("arst_idle_busy", 32'(busy_a), 32'd0);
    check("arst_idle_done", 32'(done_a), 32'd0);

    // Randomized frames on the 4x4 instance with gapped pixels and ready
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int n;
      bit short_f;
      short_f = ($urandom_range(0, 1) == 1);
      n = short_f ? int'($urandom_range(1, 15)) : H * VB;
      start_capture();
      repeat ($urandom_range(0, 2)) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      vs_edge();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      end
      if (short_f) vs_edge();
      else repeat (2) send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      wait_done($sformatf("rnd%0d_done", f), 1'b1, 100);
      check($sformatf("rnd%0d_cnt", f), 32'(cnt_b), 32'(n));
      check($sformatf("rnd%0d_short", f), 32'(short_b), 32'(short_f));
      check($sformatf("rnd%0d_ovf", f), 32'(ovf_b), 32'd0);
      check_stream($sformatf("rnd%0d", f), 1'b1, n / 2);
    end
    rand_ready = 1'b0;
    ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_frame_capture.md
# rgb_frame_capture

Single-shot frame grabber downstream of the Bayer-to-RGB stage. It takes the RGB888 pixel stream on the VGA pixel clock and, on request, captures exactly one complete frame starting at the next frame boundary. Each pixel is packed to RGB565, pixel pairs are packed into 32-bit words, and the words are delivered through an internal FIFO on a valid/ready interface to the memory-write master feeding the HPS snapshot buffer.

## Interface
- H_ACTIVE, 640, active pixels per line; must be even.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 16, FIFO depth in 32-bit words; must be a power of 2, ≥ 4.
- VGA_CLK  in  1  pixel clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- iRed / iGreen / iBlue  in  8 each  pixel colour, qualified by READ_Request.
- READ_Request  in  1  pixel valid, one pixel per high cycle.
- VGA_VS  in  1  vertical sync, active low; frame start is the 0→1 transition.
- iCapture  in  1  single-cycle capture request.
- iAbort  in  1  single-cycle abort.
- oWord  out  32  packed pixel pair.
- oWordValid  out  1  oWord is valid.
- iWordReady  in  1  consumer accepts the word when oWordValid && iWordReady.
- oBusy  out  1  high in ARMED, CAPTURE and DRAIN.
- oDone  out  1  high in DONE.
- oOverflow  out  1  sticky: a word was dropped because the FIFO was full.
- oShortFrame  out  1  sticky: a VS edge arrived before the frame completed.
- oPixCount  out  19  pixels accepted in the current capture.

## Operation
- **Packing**
  - RGB565 = {R[7:3], G[7:2], B[7:3]}.
  - The even-indexed pixel (0, 2, …) goes in oWord[15:0]; the following odd pixel goes in [31:16].
  - A word is pushed on the cycle after its odd pixel is accepted.
- **FSM states:** IDLE, ARMED, CAPTURE, DRAIN, DONE.
  - IDLE or DONE, iCapture → ARMED. Entering ARMED clears oOverflow, oShortFrame, oPixCount and the pack half-register.
  - ARMED, VS 0→1 edge → CAPTURE. Pixels seen while ARMED are ignored.
  - CAPTURE, READ_Request → the pixel is accepted and oPixCount increments.
  - CAPTURE, pixel number H_ACTIVE*V_ACTIVE accepted → DRAIN. Later pixels are ignored.
  - CAPTURE, VS 0→1 edge before the frame completes → DRAIN, with oShortFrame set. A pending unpaired even pixel is discarded.
  - DRAIN, FIFO empty and no push pending → DONE.
  - DONE holds until iCapture.
- **Abort**
  - iAbort in any state → IDLE. The FIFO and pack register are flushed.
  - oPixCount and the sticky flags are held.
  - If iAbort and iCapture arrive in the same cycle, abort wins.
  - iCapture in ARMED, CAPTURE or DRAIN is ignored.
- **Overflow:** a push while the FIFO is full drops the word and sets oOverflow. Capture and counting continue normally.
- **VS edge detect:** VS is registered once; an edge is prev==0 && cur==1.
- **Reset:** state IDLE; all outputs 0, including oWord; FIFO empty; VS history register = 1.

## Timing
- **Latency:** odd pixel accepted at cycle n → FIFO write at n+1 → oWordValid high with oWord stable at n+2 (FIFO previously empty).
- **FIFO behaviour**
  - The FIFO is first-word-fall-through.
  - oWord and oWordValid hold until accepted.
  - A simultaneous push and pop when full is allowed, and is not an overflow.
- **Full/empty:** full = FIFO_DEPTH entries held; empty = 0 entries held. Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit.
- **State transitions:**
  - ARMED→CAPTURE occurs the cycle after the registered edge; a pixel in that same cycle is accepted.
  - DRAIN→DONE occurs the cycle after the last word is popped.
- **Throughput:** one pixel per cycle is sustained with no stall on the input side; the input has no back-pressure.

## Structure
- **Package rgb_capture_pkg:**
  - state enum;
  - rgb565 pack function;
  - PIX_TOTAL = H_ACTIVE*V_ACTIVE;
  - count width constant (19).
- **Sub-module capture_fifo:**
  - synchronous FWFT FIFO;
  - parameters DEPTH and WIDTH;
  - ports push, pop, full, empty, flush, din, dout.
- **Top level:** FSM, VS edge detect, pack register, counters.

## Test plan
Unless noted, use H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4.
- **Basic frame:** iCapture, then VS edge, then 8 pixels with R=G=B=8'hFF, then 8'h00 alternating → 4 words 32'h0000FFFF in order, oPixCount=8, oDone=1, no flags set.
- **Back-pressure:** iWordReady=0 during capture, with V_ACTIVE=4 (16 pixels) → 4 words stored; words 5–8 dropped; oOverflow=1; oPixCount=16. Releasing ready delivers exactly 4 words, then DONE.
- **Short frame:** second VS edge after 5 pixels → 2 words delivered, odd pixel 5 discarded, oShortFrame=1, oDone=1.
- **Abort mid-capture:** iAbort after 3 pixels with 1 word queued → IDLE next cycle; oWordValid=0; oPixCount=3. A subsequent iCapture clears the count to 0.
- **Request edge cases:**
  - iCapture and iAbort in the same cycle from IDLE → stays IDLE.
  - iCapture during CAPTURE → ignored.
  - Pixels in ARMED before the VS edge → not counted.
- **Reset:** RST_N asserted mid-CAPTURE → all outputs 0 immediately (asynchronous), state IDLE after release.
